// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: read-side drain stage for an async FIFO (rclk domain).
// Pops bytes from the FIFO read port into a 2-entry skid buffer and presents
// them as a valid/ready byte stream with packet framing.
//   rclk, rrst    : clock, synchronous active-high reset
//   en            : drain enable (gates new pops only)
//   rempty, rdata : FIFO read side; rinc : FIFO pop strobe
//   m_valid/m_ready/m_data/m_last : output byte stream
//   level         : skid-buffer occupancy 0..2
//   pkt_cnt       : completed packets since reset (wraps)
module fifo_rd_streamer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PKT_LEN = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              en,
    input  logic              rempty,
    input  logic [DATA_W-1:0] rdata,
    output logic              rinc,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [1:0]        level,
    output logic [CNT_W-1:0]  pkt_cnt
);

    localparam int unsigned      BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [1:0]        r_level;
    logic [BEAT_W-1:0] r_beat;
    logic [CNT_W-1:0]  r_pkt_cnt;

    logic w_push;
    logic w_pop;
    logic w_last;

    // Pop decision uses only registered occupancy, never m_ready.
    assign w_push = en & ~rempty & ~rrst & (r_level != 2'd2);
    assign w_pop  = (r_level != 2'd0) & m_ready;
    assign w_last = (r_beat == LAST_BEAT);

    // Skid buffer: r_head is always the oldest entry, r_tail the second.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_level   <= 2'd0;
            r_beat    <= '0;
            r_pkt_cnt <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_level == 2'd0) begin
                        r_head <= rdata;
                    end else begin
                        r_tail <= rdata;
                    end
                    r_level <= r_level + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_level <= r_level - 2'd1;
                end
                // Push+pop only happens at level 1: new byte becomes the head.
                2'b11: begin
                    r_head <= rdata;
                end
                default: begin
                end
            endcase

            if (w_pop) begin
                r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
                if (w_last) begin
                    r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign rinc    = w_push;
    assign m_valid = (r_level != 2'd0);
    assign m_data  = r_head;
    assign m_last  = (r_level != 2'd0) & w_last;
    assign level   = r_level;
    assign pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: a queue models the upstream FIFO, a scoreboard
// queue holds expected bytes, and a monitor checks the stream every cycle.
// Two instances share stimulus: PKT_LEN=4 (main) and PKT_LEN=1.
module tb_fifo_rd_streamer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PKT    = 4;

    logic              rclk = 1'b0;
    logic              rrst;
    logic              en;
    logic              rempty;
    logic [DATA_W-1:0] rdata;
    logic              m_ready;

    logic              rinc, m_valid, m_last;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        level;
    logic [CNT_W-1:0]  pkt_cnt;

    logic              rinc1, m_valid1, m_last1;
    logic [DATA_W-1:0] m_data1;
    logic [1:0]        level1;
    logic [CNT_W-1:0]  pkt_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              tb_pop = 1'b0;

    int mdl_level = 0;
    int mdl_beat  = 0;
    int mdl_pkt   = 0;
    int mdl_pkt1  = 0;
    bit rst_prev  = 1'b0;

    fifo_rd_streamer #(.DATA_W(DATA_W), .PKT_LEN(PKT), .CNT_W(CNT_W)) u_dut (
        .rclk(rclk), .rrst(rrst), .en(en), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .level(level), .pkt_cnt(pkt_cnt)
    );

    fifo_rd_streamer #(.DATA_W(DATA_W), .PKT_LEN(1), .CNT_W(CNT_W)) u_dut1 (
        .rclk(rclk), .rrst(rrst), .en(en), .rempty(rempty), .rdata(rdata),
        .rinc(rinc1), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
        .m_last(m_last1), .level(level1), .pkt_cnt(pkt_cnt1)
    );

    always #5 rclk = ~rclk;

    // Capture the pop strobe at the edge where the FIFO pointer advances.
    always @(posedge rclk) tb_pop <= rinc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic update_pins();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? 8'h00 : fifo_q[0];
    endtask

    task automatic tick();
        @(negedge rclk);
        if (tb_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        update_pins();
    endtask

    task automatic push_byte(input logic [DATA_W-1:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        update_pins();
    endtask

    task automatic drain();
        int n = 0;
        while ((fifo_q.size() != 0 || mdl_level != 0) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 50), 32'd1);
    endtask

    // Monitor: samples between the falling edge (stimulus) and rising edge.
    always @(negedge rclk) begin
        int  exp_rinc;
        bit  hs;
        #2;
        if (rrst) begin
            chk("rst_rinc", 32'(rinc), 32'd0);
            if (rst_prev) begin
                chk("rst_m_valid", 32'(m_valid), 32'd0);
                chk("rst_m_last", 32'(m_last), 32'd0);
                chk("rst_level", 32'(level), 32'd0);
                chk("rst_m_data", 32'(m_data), 32'd0);
                chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
            end
            // Buffered bytes are discarded; bytes still in the FIFO survive.
            for (int i = 0; i < mdl_level; i++) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            mdl_level = 0;
            mdl_beat  = 0;
            mdl_pkt   = 0;
            mdl_pkt1  = 0;
            rst_prev  = 1'b1;
        end else begin
            rst_prev = 1'b0;
            exp_rinc = (en && !rempty && mdl_level < 2) ? 1 : 0;
            chk("rinc", 32'(rinc), 32'(exp_rinc));
            chk("rinc_while_empty", 32'(rinc & rempty), 32'd0);
            chk("level", 32'(level), 32'(mdl_level));
            chk("m_valid", 32'(m_valid), 32'(mdl_level != 0));
            chk("pkt_cnt", 32'(pkt_cnt), 32'(mdl_pkt));
            chk("pkt_cnt_len1", 32'(pkt_cnt1), 32'(mdl_pkt1));
            chk("m_last_len1", 32'(m_last1), 32'(m_valid1));
            if (mdl_level != 0) begin
                if (exp_q.size() == 0) begin
                    chk("m_data_unexpected", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    chk("m_data", 32'(m_data), 32'(exp_q[0]));
                end
                chk("m_last", 32'(m_last), 32'(mdl_beat == PKT - 1));
            end
            hs = (mdl_level != 0) && m_ready;
            if (hs) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (mdl_beat == PKT - 1) begin
                    mdl_beat = 0;
                    mdl_pkt  = (mdl_pkt + 1) % (1 << CNT_W);
                end else begin
                    mdl_beat++;
                end
                mdl_pkt1 = (mdl_pkt1 + 1) % (1 << CNT_W);
            end
            mdl_level = mdl_level + exp_rinc - (hs ? 1 : 0);
        end
    end

    initial begin
        rrst    = 1'b1;
        en      = 1'b1;
        m_ready = 1'b1;
        update_pins();

        // Reset with a non-empty FIFO: no pops during reset.
        for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i));
        repeat (3) tick();
        rrst = 1'b0;

        // Streaming 0x10..0x17: two packets.
        drain();
        chk("stream_pkt_cnt", 32'(pkt_cnt), 32'd2);
        chk("stream_pkt_cnt_len1", 32'(pkt_cnt1), 32'd8);

        // Backpressure: only two pops, head held.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h20 + i));
        repeat (5) tick();
        chk("bp_level", 32'(level), 32'd2);
        chk("bp_m_data", 32'(m_data), 32'h20);
        chk("bp_fifo_left", 32'(fifo_q.size()), 32'd3);
        m_ready = 1'b1;
        drain();
        chk("bp_pkt_cnt", 32'(pkt_cnt), 32'd3);

        // Empty boundary: single byte.
        push_byte(8'hA5);
        drain();
        repeat (2) tick();
        chk("empty_level", 32'(level), 32'd0);

        // en gating: data waits in FIFO, nothing popped.
        en = 1'b0;
        push_byte(8'h30);
        push_byte(8'h31);
        push_byte(8'h32);
        repeat (3) tick();
        chk("en_level", 32'(level), 32'd0);
        chk("en_fifo_left", 32'(fifo_q.size()), 32'd3);
        en = 1'b1;
        drain();
        chk("en_pkt_cnt", 32'(pkt_cnt), 32'd4);
        chk("en_pkt_cnt_len1", 32'(pkt_cnt1), 32'd17);

        // Reset mid-packet with a full skid buffer.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(8'(8'h40 + i));
        begin
            int n = 0;
            while (mdl_level != 2 && n < 10) begin
                tick();
                n++;
            end
        end
        m_ready = 1'b1;
        repeat (2) tick();
        m_ready = 1'b0;
        tick();
        chk("mid_level_before_rst", 32'(level), 32'd2);
        chk("mid_head_before_rst", 32'(m_data), 32'h42);
        rrst = 1'b1;
        tick();
        chk("mid_level_after_rst", 32'(level), 32'd0);
        rrst    = 1'b0;
        m_ready = 1'b1;
        drain();
        chk("mid_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("mid_pkt_cnt_len1", 32'(pkt_cnt1), 32'd2);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
